disparity_search_wta: RTL and testbench

- Sequencer and winner-take-all stage directly downstream of calculate_ssd_block; also drives that block's request side.
- For one left-image 6x6 block at (left_x, left_y), issues SSD requests for candidate disparities d = 0..MAX_DISP-1. Each request uses right_x = left_x + d and the same y.
- Collects each returned ssd value and tracks the minimum.
- Emits the winning disparity and its SSD to the depth-map writer.

---
 rtl/stereo_pkg.sv | 27 ++
 rtl/disparity_search_wta.sv | 150 +++++++++++++++
 tb/tb_disparity_search_wta.sv | 286 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/stereo_pkg.sv
`default_nettype none
// ============================================================================
// Module      : stereo_pkg
// Description : Shared geometry constants and WTA state type for the stereo
//               block-matching pipeline (SSD unit and disparity search).
// Revision    : 1.0 - initial release
// ============================================================================
package stereo_pkg;

    localparam int IMG_W    = 240;
    localparam int IMG_H    = 320;
    localparam int BLOCK    = 6;
    localparam int X_W      = 9;
    localparam int Y_W      = 10;
    localparam int SSD_W    = 23;
    localparam int MAX_DISP = 16;
    localparam int D_W      = 6;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        DONE  = 2'd3
    } wta_state_t;

endpackage
`default_nettype wire

// File: rtl/disparity_search_wta.sv
`default_nettype none
// ============================================================================
// Module      : disparity_search_wta
// Description : Issues one SSD request per candidate disparity for a 6x6 left
//               block and reports the winner-take-all disparity and its SSD.
// Revision    : 1.0 - initial release
// ============================================================================
module disparity_search_wta #(
    parameter int MAX_DISP = stereo_pkg::MAX_DISP,
    parameter int BLOCK    = stereo_pkg::BLOCK,
    parameter int IMG_W    = stereo_pkg::IMG_W,
    parameter int X_W      = stereo_pkg::X_W,
    parameter int Y_W      = stereo_pkg::Y_W,
    parameter int SSD_W    = stereo_pkg::SSD_W,
    parameter int D_W      = stereo_pkg::D_W
) (
    input  logic             clk_in,
    input  logic             rst_in,
    input  logic             start_in,
    input  logic [X_W-1:0]   left_x_in,
    input  logic [Y_W-1:0]   left_y_in,
    output logic             busy_out,
    output logic             ssd_valid_out,
    output logic [X_W-1:0]   ssd_left_x_out,
    output logic [X_W-1:0]   ssd_right_x_out,
    output logic [Y_W-1:0]   ssd_y_out,
    input  logic             ssd_valid_in,
    input  logic [SSD_W-1:0] ssd_in,
    output logic             valid_out,
    output logic [D_W-1:0]   disp_out,
    output logic [SSD_W-1:0] min_ssd_out,
    output logic             no_match_out
);
    import stereo_pkg::*;

    // Counter is one wider than needed for MAX_DISP-1 so it can reach MAX_DISP.
    localparam int                 c_cnt_w    = $clog2(MAX_DISP + 1);
    localparam logic [c_cnt_w-1:0] c_max_disp = c_cnt_w'(MAX_DISP);
    localparam logic [X_W:0]       c_img_w    = (X_W + 1)'(IMG_W);
    localparam logic [X_W:0]       c_block    = (X_W + 1)'(BLOCK);

    wta_state_t         state_q,    state_d;
    logic [X_W-1:0]     left_x_q,   left_x_d;
    logic [Y_W-1:0]     left_y_q,   left_y_d;
    logic [c_cnt_w-1:0] d_q,        d_d;
    logic [D_W-1:0]     best_d_q,   best_d_d;
    logic [SSD_W-1:0]   best_ssd_q, best_ssd_d;
    logic [D_W-1:0]     disp_q,     disp_d;
    logic [SSD_W-1:0]   min_ssd_q,  min_ssd_d;
    logic               no_match_q, no_match_d;

    logic [X_W:0]       right_x_ext;
    logic [X_W:0]       block_end;
    logic               stop;

    // One extra bit keeps left_x + d + BLOCK from wrapping before the edge test.
    assign right_x_ext = {1'b0, left_x_q} + (X_W + 1)'(d_q);
    assign block_end   = right_x_ext + c_block;
    assign stop        = (block_end > c_img_w) || (d_q == c_max_disp);

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state_q    <= IDLE;
            left_x_q   <= '0;
            left_y_q   <= '0;
            d_q        <= '0;
            best_d_q   <= '0;
            best_ssd_q <= '1;
            disp_q     <= '0;
            min_ssd_q  <= '1;
            no_match_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            left_x_q   <= left_x_d;
            left_y_q   <= left_y_d;
            d_q        <= d_d;
            best_d_q   <= best_d_d;
            best_ssd_q <= best_ssd_d;
            disp_q     <= disp_d;
            min_ssd_q  <= min_ssd_d;
            no_match_q <= no_match_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        left_x_d   = left_x_q;
        left_y_d   = left_y_q;
        d_d        = d_q;
        best_d_d   = best_d_q;
        best_ssd_d = best_ssd_q;
        disp_d     = disp_q;
        min_ssd_d  = min_ssd_q;
        no_match_d = no_match_q;
        case (state_q)
            IDLE: begin
                if (start_in) begin
                    left_x_d   = left_x_in;
                    left_y_d   = left_y_in;
                    d_d        = '0;
                    best_d_d   = '0;
                    best_ssd_d = '1;
                    state_d    = ISSUE;
                end
            end
            ISSUE: begin
                if (stop) begin
                    disp_d     = best_d_q;
                    min_ssd_d  = best_ssd_q;
                    no_match_d = (d_q == '0);
                    state_d    = DONE;
                end else begin
                    state_d    = WAIT;
                end
            end
            WAIT: begin
                if (ssd_valid_in) begin
                    // Strict compare: on a tie the earlier (smaller) disparity wins.
                    if (ssd_in < best_ssd_q) begin
                        best_ssd_d = ssd_in;
                        best_d_d   = D_W'(d_q);
                    end
                    d_d     = d_q + c_cnt_w'(1);
                    state_d = ISSUE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_comb begin
        busy_out      = (state_q == ISSUE) || (state_q == WAIT);
        ssd_valid_out = (state_q == ISSUE) && !stop;
        valid_out     = (state_q == DONE);
    end

    assign ssd_left_x_out  = left_x_q;
    assign ssd_right_x_out = right_x_ext[X_W-1:0];
    assign ssd_y_out       = left_y_q;
    assign disp_out        = disp_q;
    assign min_ssd_out     = min_ssd_q;
    assign no_match_out    = no_match_q;

endmodule
`default_nettype wire

// File: tb/tb_disparity_search_wta.sv
`default_nettype none
// ============================================================================
// Module      : tb_disparity_search_wta
// Description : Self-checking bench for disparity_search_wta with an SSD stub
//               and a behavioural winner-take-all reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_disparity_search_wta;
    import stereo_pkg::*;

    localparam longint c_ssd_ones = (64'd1 << SSD_W) - 1;

    logic             clk_in = 1'b0;
    logic             rst_in;
    logic             start_in;
    logic [X_W-1:0]   left_x_in;
    logic [Y_W-1:0]   left_y_in;
    logic             busy_out;
    logic             ssd_valid_out;
    logic [X_W-1:0]   ssd_left_x_out;
    logic [X_W-1:0]   ssd_right_x_out;
    logic [Y_W-1:0]   ssd_y_out;
    logic             ssd_valid_in;
    logic [SSD_W-1:0] ssd_in;
    logic             valid_out;
    logic [D_W-1:0]   disp_out;
    logic [SSD_W-1:0] min_ssd_out;
    logic             no_match_out;

    disparity_search_wta u_dut (
        .clk_in          (clk_in),
        .rst_in          (rst_in),
        .start_in        (start_in),
        .left_x_in       (left_x_in),
        .left_y_in       (left_y_in),
        .busy_out        (busy_out),
        .ssd_valid_out   (ssd_valid_out),
        .ssd_left_x_out  (ssd_left_x_out),
        .ssd_right_x_out (ssd_right_x_out),
        .ssd_y_out       (ssd_y_out),
        .ssd_valid_in    (ssd_valid_in),
        .ssd_in          (ssd_in),
        .valid_out       (valid_out),
        .disp_out        (disp_out),
        .min_ssd_out     (min_ssd_out),
        .no_match_out    (no_match_out)
    );

    always #5 clk_in = ~clk_in;

    int cyc = 0;
    always @(posedge clk_in) cyc <= cyc + 1;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk_eq(input string tag, input longint obs, input longint exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    // SSD stub: answers each request after stub_lat cycles from the cost table.
    int cost [64];
    int stub_lat  = 3;
    int spur_req  = 0;
    int spur_done = 0;
    int req_rx[$];
    int req_lx[$];
    int req_y[$];
    int req_cyc[$];
    int resp_cyc[$];

    initial begin
        ssd_valid_in = 1'b0;
        ssd_in       = '0;
        forever begin
            @(negedge clk_in);
            ssd_valid_in = 1'b0;
            if (ssd_valid_out) begin
                int dd;
                req_rx.push_back(int'(ssd_right_x_out));
                req_lx.push_back(int'(ssd_left_x_out));
                req_y.push_back(int'(ssd_y_out));
                req_cyc.push_back(cyc);
                dd = int'(ssd_right_x_out) - int'(ssd_left_x_out);
                repeat (stub_lat - 1) @(negedge clk_in);
                ssd_in       = (dd >= 0 && dd < 64) ? SSD_W'(cost[dd]) : '1;
                ssd_valid_in = 1'b1;
                resp_cyc.push_back(cyc);
            end else if (spur_req != spur_done) begin
                spur_done++;
                ssd_in       = '0;
                ssd_valid_in = 1'b1;
            end
        end
    end

    int     vo_cnt  = 0;
    int     vo_cyc  = 0;
    int     vo_disp = 0;
    int     vo_nm   = 0;
    int     vo_busy = 0;
    longint vo_min  = 0;

    always @(negedge clk_in) begin
        if (valid_out) begin
            vo_cnt  <= vo_cnt + 1;
            vo_cyc  <= cyc;
            vo_disp <= int'(disp_out);
            vo_min  <= longint'(min_ssd_out);
            vo_nm   <= int'(no_match_out);
            vo_busy <= int'(busy_out);
        end
    end

    task automatic clear_log();
        req_rx.delete();
        req_lx.delete();
        req_y.delete();
        req_cyc.delete();
        resp_cyc.delete();
    endtask

    // Reference: legal candidates are d with x+d+BLOCK <= IMG_W, d < MAX_DISP;
    // winner is the first index holding the minimum, provided it beats all-ones.
    function automatic void model(input int x, output int n, output int ed,
                                  output longint em, output int enm);
        bit found;
        n = IMG_W - BLOCK - x + 1;
        if (n < 0) n = 0;
        if (n > MAX_DISP) n = MAX_DISP;
        em = c_ssd_ones;
        for (int i = 0; i < n; i++)
            if (longint'(cost[i]) < em) em = longint'(cost[i]);
        ed    = 0;
        found = 1'b0;
        if (em < c_ssd_ones)
            for (int i = 0; i < n; i++)
                if (!found && longint'(cost[i]) == em) begin
                    ed    = i;
                    found = 1'b1;
                end
        enm = (n == 0) ? 1 : 0;
    endfunction

    task automatic run_search(input string name, input int x, input int y,
                              input int lat, input bit extra_start);
        int     base_vo, start_c, n, ed, enm, last_c;
        longint em;
        bit     got, extra_done;
        stub_lat   = lat;
        clear_log();
        base_vo    = vo_cnt;
        got        = 1'b0;
        extra_done = 1'b0;
        model(x, n, ed, em, enm);
        @(negedge clk_in);
        start_in  = 1'b1;
        left_x_in = X_W'(x);
        left_y_in = Y_W'(y);
        start_c   = cyc;
        for (int t = 0; t < 4000 && !got; t++) begin
            @(negedge clk_in);
            start_in = 1'b0;
            if (vo_cnt != base_vo) begin
                got = 1'b1;
            end else if (extra_start && !extra_done && req_rx.size() == 2) begin
                start_in   = 1'b1;
                left_x_in  = '0;
                extra_done = 1'b1;
            end
        end
        start_in = 1'b0;
        repeat (8) @(negedge clk_in);

        chk_eq({name, " completed"}, got, 1);
        chk_eq({name, " valid_out pulses"}, vo_cnt - base_vo, 1);
        chk_eq({name, " request count"}, req_rx.size(), n);
        for (int i = 0; i < req_rx.size() && i < n; i++) begin
            chk_eq({name, " right_x"}, req_rx[i], x + i);
            chk_eq({name, " left_x"}, req_lx[i], x);
            chk_eq({name, " y"}, req_y[i], y);
        end
        if (n > 0 && req_cyc.size() > 0)
            chk_eq({name, " start-to-request latency"}, req_cyc[0] - start_c, 1);
        for (int i = 1; i < req_cyc.size() && i < resp_cyc.size() + 1; i++)
            chk_eq({name, " result-to-request latency"}, req_cyc[i] - resp_cyc[i-1], 1);
        last_c = (n == 0 || resp_cyc.size() == 0) ? start_c : resp_cyc[resp_cyc.size()-1];
        chk_eq({name, " final latency"}, vo_cyc - last_c, 2);
        chk_eq({name, " disp_out"}, vo_disp, ed);
        chk_eq({name, " min_ssd_out"}, vo_min, em);
        chk_eq({name, " no_match_out"}, vo_nm, enm);
        chk_eq({name, " busy at valid"}, vo_busy, 0);
        chk_eq({name, " disp held"}, disp_out, ed);
    endtask

    initial begin
        int base_vo;
        rst_in    = 1'b1;
        start_in  = 1'b0;
        left_x_in = '0;
        left_y_in = '0;
        repeat (3) @(negedge clk_in);
        rst_in = 1'b0;
        @(negedge clk_in);
        chk_eq("reset busy_out", busy_out, 0);
        chk_eq("reset ssd_valid_out", ssd_valid_out, 0);
        chk_eq("reset valid_out", valid_out, 0);
        chk_eq("reset no_match_out", no_match_out, 0);
        chk_eq("reset disp_out", disp_out, 0);
        chk_eq("reset min_ssd_out", min_ssd_out, c_ssd_ones);
        chk_eq("reset ssd_right_x_out", ssd_right_x_out, 0);

        for (int i = 0; i < 64; i++) cost[i] = 1000 - 50 * i;
        run_search("descending", 0, 0, 3, 1'b0);

        for (int i = 0; i < 64; i++) cost[i] = 500;
        run_search("all ties", 17, 5, 3, 1'b0);

        for (int i = 0; i < 64; i++) cost[i] = 900 - i;
        run_search("right edge", 228, 40, 3, 1'b0);

        run_search("no match", 236, 12, 3, 1'b0);

        for (int i = 0; i < 64; i++) cost[i] = int'(c_ssd_ones);
        run_search("all-ones costs", 50, 7, 2, 1'b0);

        // Reset while waiting on the third result; the late result must be ignored.
        for (int i = 0; i < 64; i++) cost[i] = 300 + i;
        stub_lat = 8;
        clear_log();
        base_vo = vo_cnt;
        @(negedge clk_in);
        start_in  = 1'b1;
        left_x_in = X_W'(10);
        left_y_in = Y_W'(3);
        @(negedge clk_in);
        start_in = 1'b0;
        for (int t = 0; t < 200 && req_rx.size() < 3; t++) @(negedge clk_in);
        chk_eq("mid reset requests before reset", req_rx.size(), 3);
        rst_in = 1'b1;
        @(negedge clk_in);
        rst_in = 1'b0;
        repeat (20) @(negedge clk_in);
        chk_eq("mid reset no valid_out", vo_cnt - base_vo, 0);
        chk_eq("mid reset busy_out", busy_out, 0);
        chk_eq("mid reset no new request", req_rx.size(), 3);
        chk_eq("mid reset late result returned", resp_cyc.size(), 3);
        chk_eq("mid reset disp_out", disp_out, 0);
        chk_eq("mid reset min_ssd_out", min_ssd_out, c_ssd_ones);

        for (int i = 0; i < 64; i++) cost[i] = 1000 - ((i - 9) * (i - 9));
        for (int i = 0; i < 64; i++) cost[i] = (i == 9) ? 20 : 400 + i;
        run_search("after reset", 30, 100, 4, 1'b0);

        run_search("start while busy", 30, 100, 4, 1'b1);

        clear_log();
        base_vo = vo_cnt;
        spur_req++;
        repeat (6) @(negedge clk_in);
        chk_eq("spurious result valid_out", vo_cnt - base_vo, 0);
        chk_eq("spurious result requests", req_rx.size(), 0);
        chk_eq("spurious result busy_out", busy_out, 0);
        run_search("after spurious", 30, 100, 4, 1'b0);

        for (int k = 0; k < 12; k++) begin
            int x, y, lat, span;
            x    = ($urandom_range(0, 1) == 1) ? int'($urandom_range(0, IMG_W - 1))
                                               : int'($urandom_range(IMG_W - BLOCK - MAX_DISP, IMG_W - 1));
            y    = int'($urandom_range(0, 319));
            lat  = int'($urandom_range(2, 5));
            span = ($urandom_range(0, 1) == 1) ? 7 : 3000;
            for (int i = 0; i < 64; i++) cost[i] = int'($urandom_range(0, span));
            run_search("random", x, y, lat, 1'b0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
